// File: rtl/ball_sprite_pkg.sv
// ball_sprite_pkg: shared game constants, colours and capture FSM encoding.
package ball_sprite_pkg;
  localparam int HRES = 640;
  localparam int VRES = 480;
  localparam int SIZE = 16;
  localparam int MAX_RETRY = 8;
  localparam logic [9:0] BALL_X0 = 10'd276;
  localparam logic [8:0] BALL_Y0 = 9'd320;
  localparam logic BALL_DIR0 = 1'b1;
  typedef logic [11:0] rgb444_t;
  localparam rgb444_t COLOR_UP = 12'hFA0;
  localparam rgb444_t COLOR_DN = 12'hF40;
  typedef enum logic [1:0] {HOLD, CAP, CMP} cap_state_t;
endpackage

// File: rtl/ball_rom.sv
// ball_rom: 32x16 registered ball bitmap, rising shape in rows 0-15, falling in 16-31.
module ball_rom (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  addr,
  output logic [15:0] data
);
  localparam logic [15:0] BITMAP [32] = '{
    16'h07E0, 16'h0FF0, 16'h0FF0, 16'h1FF8, 16'h1FF8, 16'h1FF8, 16'h1FF8, 16'h1FF8,
    16'h1FF8, 16'h1FF8, 16'h1FF8, 16'h1FF8, 16'h0FF0, 16'h0FF0, 16'h07E0, 16'h03C0,
    16'h07E0, 16'h1FF8, 16'h3FFC, 16'h3FFC, 16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h7FFE,
    16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h3FFC, 16'h3FFC, 16'h1FF8, 16'h07E0
  };
  always_ff @(posedge clk or negedge reset)
    if (!reset) data <= '0;
    else data <= BITMAP[addr];
endmodule

// File: rtl/ball_sprite.sv
// ball_sprite: per-frame tear-free position capture and 3-stage ball pixel renderer.
module ball_sprite #(
  parameter int SIZE = ball_sprite_pkg::SIZE,
  parameter int HRES = ball_sprite_pkg::HRES,
  parameter int VRES = ball_sprite_pkg::VRES,
  parameter ball_sprite_pkg::rgb444_t COLOR_UP = ball_sprite_pkg::COLOR_UP,
  parameter ball_sprite_pkg::rgb444_t COLOR_DN = ball_sprite_pkg::COLOR_DN,
  parameter int MAX_RETRY = ball_sprite_pkg::MAX_RETRY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  ball_x,
  input  logic [8:0]  ball_y,
  input  logic        ball_dir,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic        pix_valid,
  output logic [11:0] pix_rgb,
  output logic        frame_ready,
  output logic        stale
);
  import ball_sprite_pkg::*;
  localparam int CW = MAX_RETRY > 1 ? $clog2(MAX_RETRY) : 1;
  logic [9:0] rx, lx;
  logic [8:0] ry, ly;
  logic rd, ldir;
  logic [19:0] s1, raw;
  logic [CW-1:0] cnt;
  cap_state_t state, state_n;
  logic boundary, match, last, load, commit, give_up;
  logic [10:0] dx, dy;
  logic in0, in1, dir0, dir1, hit;
  logic [3:0] col0, row0, col1;
  logic [15:0] rowbits;
  assign raw = {rx, ry, rd};
  assign boundary = vcount == 10'(VRES) && hcount == '0;
  assign match = raw == s1;
  assign last = cnt == CW'(MAX_RETRY - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= HOLD;
    else state <= state_n;
  always_comb
    state_n = (state == HOLD) ? (boundary ? CAP : HOLD) :
              (state == CAP) ? CMP :
              (state == CMP && !match && !last) ? CMP : HOLD;
  always_comb begin
    load = state == CAP || (state == CMP && !match && !last);
    commit = state == CMP && match;
    give_up = state == CMP && !match && last;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx <= '0;
      ry <= '0;
      rd <= 1'b0;
      s1 <= '0;
      cnt <= '0;
      lx <= BALL_X0;
      ly <= BALL_Y0;
      ldir <= BALL_DIR0;
      frame_ready <= 1'b0;
      stale <= 1'b0;
    end else begin
      rx <= ball_x;
      ry <= ball_y;
      rd <= ball_dir;
      if (load) s1 <= raw;
      if (state == CAP) cnt <= '0;
      else if (load) cnt <= cnt + 1'b1;
      if (commit) {lx, ly, ldir} <= s1;
      frame_ready <= commit;
      stale <= give_up;
    end
  // 11-bit differences keep the sign, so sprites past an edge clip instead of wrapping
  assign dx = {1'b0, hcount} - {1'b0, lx};
  assign dy = {1'b0, vcount} - {2'b0, ly};
  assign hit = in1 && rowbits[4'd15 - col1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      in0 <= 1'b0;
      col0 <= '0;
      row0 <= '0;
      dir0 <= 1'b0;
      in1 <= 1'b0;
      col1 <= '0;
      dir1 <= 1'b0;
      pix_valid <= 1'b0;
      pix_rgb <= '0;
    end else begin
      in0 <= !dx[10] && dx < 11'(SIZE) && !dy[10] && dy < 11'(SIZE) &&
             hcount < 10'(HRES) && vcount < 10'(VRES);
      col0 <= dx[3:0];
      row0 <= dy[3:0];
      dir0 <= ldir;
      in1 <= in0;
      col1 <= col0;
      dir1 <= dir0;
      pix_valid <= hit;
      pix_rgb <= hit ? (dir1 ? COLOR_UP : COLOR_DN) : '0;
    end
  // rising bitmaps occupy the lower half of the ROM
  ball_rom u_rom (.clk(clk), .reset(reset), .addr({~dir0, row0}), .data(rowbits));
endmodule
